// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the FIFO-to-UART transmit path.
//   - tx_state_t : word-level FSM states (fifo_uart_tx) and bit-level phases
//                  (uart_tx_byte) share one enum.
//   - UART framing constants for 8N1.
//   - ceil_log2_min1 : index width helper that never returns zero.
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } tx_state_t;

  localparam logic UART_START_BIT      = 1'b0;
  localparam logic UART_STOP_BIT       = 1'b1;
  localparam int   UART_BITS_PER_FRAME = 10;

  // Width needed to count 0..n-1, but at least one bit so vectors stay legal.
  function automatic int ceil_log2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx_if
//   Read-side handshake between a synchronous FIFO and its consumer.
//   fifo_empty : FIFO has no word available
//   fifo_rd_en : one-cycle read strobe from the consumer
//   fifo_data  : FIFO read data, valid the cycle after rd_en is sampled
//   modport master : consumer (owns fifo_rd_en)
//   modport slave  : FIFO (owns fifo_empty and fifo_data)
// ----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_data
  );

endinterface

// File: rtl/uart_tx_byte.sv
// ----------------------------------------------------------------------------
// uart_tx_byte
//   8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, each held
//   CLKS_PER_BIT cycles. A new byte may be launched while idle or on the very
//   last cycle of the stop bit, so consecutive bytes leave no idle gap.
//   clk        : system clock
//   reset      : synchronous active-high reset (forces the line idle-high)
//   start_i    : launch request, honoured when idle or at byte_end_o
//   data_i     : byte to send, sampled when the launch is honoured
//   tx_o       : registered serial output, idle high
//   byte_end_o : high on the final cycle of the stop bit
// ----------------------------------------------------------------------------
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_end_o
);

  localparam int               CNT_W     = ceil_log2_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        phase_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shreg_q;
  logic             tx_q;

  logic tick_s;
  logic byte_end_s;
  logic launch_s;

  // Bit-boundary and launch decode.
  always_comb begin
    tick_s     = (baud_q == LAST_TICK);
    byte_end_s = (phase_q == STOP) && tick_s;
    launch_s   = start_i && ((phase_q == IDLE) || byte_end_s);
  end

  // Serializer state, baud counter and registered line driver.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= UART_STOP_BIT;
    end else if (launch_s) begin
      phase_q <= START;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shreg_q <= data_i;
      tx_q    <= UART_START_BIT;
    end else begin
      case (phase_q)
        START: begin
          if (tick_s) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            phase_q <= DATA;
            tx_q    <= shreg_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_s) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              phase_q <= STOP;
              tx_q    <= UART_STOP_BIT;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_s) begin
            baud_q  <= '0;
            phase_q <= IDLE;
            tx_q    <= UART_STOP_BIT;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          phase_q <= IDLE;
          baud_q  <= '0;
          tx_q    <= UART_STOP_BIT;
        end
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign byte_end_o = byte_end_s;

endmodule

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//   FIFO consumer that drains DATA_WIDTH-bit words and sends each one on a
//   UART 8N1 line, least-significant byte first. One word in flight at a time.
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset; aborts any word in progress
//   enable    : permits starting a new word (checked only in IDLE)
//   fifo      : FIFO read handshake (master side: drives fifo_rd_en)
//   tx        : UART line, idle high
//   busy      : high from FETCH through the final stop bit
//   word_done : one-cycle pulse after the last stop bit of a word
// ----------------------------------------------------------------------------
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           word_done
);

  localparam int               NUM_BYTES = DATA_WIDTH / 8;
  localparam int               IDX_W     = ceil_log2_min1(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("fifo_uart_tx: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  // Word-level states only: IDLE, FETCH, LATCH, then DATA while the bytes of
  // the word are on the line. Bit-level START/DATA/STOP live in uart_tx_byte.
  tx_state_t             state_q;
  logic                  rd_en_q;
  logic                  busy_q;
  logic                  word_done_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [IDX_W-1:0]      byte_idx_q;

  logic [IDX_W-1:0] next_idx_s;
  logic             last_byte_s;
  logic             ser_start_s;
  logic [7:0]       ser_data_s;
  logic             byte_end_s;

  // Byte launch select. The first byte comes straight from the FIFO output in
  // LATCH so the start bit follows LATCH with no extra cycle; fifo_data is
  // looked at in no other state. Later bytes come from the latched word and
  // launch on the last stop-bit cycle of the previous byte.
  always_comb begin
    next_idx_s  = byte_idx_q + 1'b1;
    last_byte_s = (byte_idx_q == LAST_IDX);
    if (state_q == LATCH) begin
      ser_start_s = 1'b1;
      ser_data_s  = fifo.fifo_data[7:0];
    end else if ((state_q == DATA) && byte_end_s && !last_byte_s) begin
      ser_start_s = 1'b1;
      ser_data_s  = word_q[{next_idx_s, 3'b000} +: 8];
    end else begin
      ser_start_s = 1'b0;
      ser_data_s  = 8'h00;
    end
  end

  // Word FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      word_q      <= '0;
      byte_idx_q  <= '0;
    end else begin
      rd_en_q     <= 1'b0;
      word_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && !fifo.fifo_empty) begin
            state_q <= FETCH;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        FETCH: begin
          state_q <= LATCH;
        end
        LATCH: begin
          word_q     <= fifo.fifo_data;
          byte_idx_q <= '0;
          state_q    <= DATA;
        end
        DATA: begin
          if (byte_end_s) begin
            if (last_byte_s) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              word_done_q <= 1'b1;
            end else begin
              byte_idx_q <= next_idx_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .reset      (reset),
    .start_i    (ser_start_s),
    .data_i     (ser_data_s),
    .tx_o       (tx),
    .byte_end_o (byte_end_s)
  );

  assign fifo.fifo_rd_en = rd_en_q;
  assign busy            = busy_q;
  assign word_done       = word_done_q;

endmodule
